// File: rtl/snn_loader_pkg.sv
// snn_loader_pkg: shared constants, FSM state encoding and a count-range helper
// for the SNN weight loader.
// Optional feature macro: SNN_WEIGHT_LOADER_CHECKSUM_EN (adds the CHK state).
package snn_loader_pkg;

  localparam int WEIGHT_DEPTH = 8192;
  localparam int DW           = 16;
  localparam int CFG_W        = 7;
  localparam int LCNT_W       = 2 * CFG_W;
  localparam int NUM_LAYERS   = 4;

`ifdef SNN_WEIGHT_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_WR   = 3'd3,
    ST_NEXT = 3'd4,
    ST_CHK  = 3'd5,
    ST_DONE = 3'd6,
    ST_ERR  = 3'd7
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_WR   = 3'd3,
    ST_NEXT = 3'd4,
    ST_DONE = 3'd6,
    ST_ERR  = 3'd7
  } state_e;
`endif

  // A layer word count is usable when it is non-zero and fits the memory.
  function automatic logic count_ok(input logic [31:0] cnt, input logic [31:0] depth);
    return (cnt != 32'd0) && (cnt <= depth);
  endfunction

endpackage

// File: rtl/weight_word_packer.sv
// weight_word_packer: captures the low byte, then forms the little-endian
// weight word when the high byte arrives. The word register holds its value
// until the next high byte, so it doubles as the write-data output.
module weight_word_packer #(
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          lo_take_i,
  input  logic          hi_take_i,
  input  logic [7:0]    byte_i,
  output logic [DW-1:0] word_o
);

  logic [7:0]    lo_q;
  logic [DW-1:0] word_q;

  // Low byte is parked; the high byte completes the word in one step.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lo_q   <= '0;
      word_q <= '0;
    end else begin
      if (lo_take_i) lo_q <= byte_i;
      if (hi_take_i) word_q <= DW'({byte_i, lo_q});
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/snn_weight_loader.sv
// snn_weight_loader: streams little-endian weight words from a flash byte
// stream into up to four per-layer weight memories.
// Optional feature macro: SNN_WEIGHT_LOADER_CHECKSUM_EN -- when defined, a
// 16-bit wrapping sum of all written words is compared against a two-byte
// trailer in the CHK state.
module snn_weight_loader #(
  parameter int WEIGHT_DEPTH = snn_loader_pkg::WEIGHT_DEPTH,
  parameter int DW           = snn_loader_pkg::DW,
  parameter int CFG_W        = snn_loader_pkg::CFG_W
) (
  input  logic             wb_clk,
  input  logic             wb_rst_n,
  input  logic             i_start,
  input  logic [CFG_W-1:0] i_snn_input_channels,
  input  logic [CFG_W-1:0] i_neuron_1,
  input  logic [CFG_W-1:0] i_neuron_2,
  input  logic [CFG_W-1:0] i_neuron_3,
  input  logic [CFG_W-1:0] i_neuron_4,
  input  logic [2:0]       i_layers,
  input  logic [7:0]       i_byte_dat,
  input  logic             i_byte_valid,
  output logic             o_byte_ready,
  output logic [31:0]      o_snn_adr,
  output logic [3:0]       o_snn_we,
  output logic [DW-1:0]    o_snn_dat,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  import snn_loader_pkg::*;

  localparam int CNT_W = 2 * CFG_W;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_in  [NUM_LAYERS];
  logic [CNT_W-1:0] cnt_q   [NUM_LAYERS];
  logic [CFG_W-1:0] fan     [NUM_LAYERS+1];
  logic [NUM_LAYERS-1:0] layer_ok;
  logic             cfg_ok;
  logic [1:0]       last_q;
  logic [1:0]       layer_q;
  logic [CNT_W-1:0] adr_cnt_q;
  logic [31:0]      adr_q;
  logic [3:0]       we_q;
  logic             ready_q, busy_q, done_q, err_q;
  logic             byte_xfer;
  logic             last_word;
  logic [DW-1:0]    word;

`ifdef SNN_WEIGHT_LOADER_CHECKSUM_EN
  logic [15:0]      sum_q;
  logic [7:0]       chk_lo_q;
  logic             chk_phase_q;
`endif

  // Fan-in/fan-out chain: layer k spans fan[k] inputs to fan[k+1] outputs.
  assign fan[0] = i_snn_input_channels;
  assign fan[1] = i_neuron_1;
  assign fan[2] = i_neuron_2;
  assign fan[3] = i_neuron_3;
  assign fan[4] = i_neuron_4;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_cnt
      assign cnt_in[gi]   = CNT_W'(fan[gi]) * CNT_W'(fan[gi+1]);
      // Inactive layers never block a load, whatever their count.
      assign layer_ok[gi] = (3'(gi) >= i_layers) ||
                            count_ok(32'(cnt_in[gi]), 32'(WEIGHT_DEPTH));
    end
  endgenerate

  assign cfg_ok    = (i_layers != 3'd0) && (i_layers <= 3'd4) && (&layer_ok);
  assign byte_xfer = i_byte_valid && ready_q;
  assign last_word = (adr_cnt_q == cnt_q[layer_q] - CNT_W'(1));

  weight_word_packer #(.DW(DW)) u_packer (
    .clk_i     (wb_clk),
    .rst_ni    (wb_rst_n),
    .lo_take_i (state_q == ST_LO && byte_xfer),
    .hi_take_i (state_q == ST_HI && byte_xfer),
    .byte_i    (i_byte_dat),
    .word_o    (word)
  );

  // Next-state decode for the load sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: if (i_start) state_d = cfg_ok ? ST_LO : ST_ERR;
      ST_LO:   if (byte_xfer) state_d = ST_HI;
      ST_HI:   if (byte_xfer) state_d = ST_WR;
      ST_WR:   state_d = last_word ? ST_NEXT : ST_LO;
`ifdef SNN_WEIGHT_LOADER_CHECKSUM_EN
      ST_NEXT: state_d = (layer_q == last_q) ? ST_CHK : ST_LO;
      ST_CHK:  if (byte_xfer && chk_phase_q)
                 state_d = ({i_byte_dat, chk_lo_q} == sum_q) ? ST_DONE : ST_ERR;
`else
      ST_NEXT: state_d = (layer_q == last_q) ? ST_DONE : ST_LO;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs; outputs follow the next state so
  // they are aligned with the state they describe.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q   <= ST_IDLE;
      for (int i = 0; i < NUM_LAYERS; i++) cnt_q[i] <= '0;
      last_q    <= '0;
      layer_q   <= '0;
      adr_cnt_q <= '0;
      adr_q     <= '0;
      we_q      <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef SNN_WEIGHT_LOADER_CHECKSUM_EN
      sum_q       <= '0;
      chk_lo_q    <= '0;
      chk_phase_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef SNN_WEIGHT_LOADER_CHECKSUM_EN
      ready_q <= (state_d == ST_LO) || (state_d == ST_HI) || (state_d == ST_CHK);
`else
      ready_q <= (state_d == ST_LO) || (state_d == ST_HI);
`endif
      busy_q  <= !((state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERR));
      done_q  <= (state_d == ST_DONE);
      err_q   <= (state_d == ST_ERR);
      we_q    <= '0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (i_start) begin
            cnt_q     <= cnt_in;
            last_q    <= 2'(i_layers - 3'd1);
            layer_q   <= '0;
            adr_cnt_q <= '0;
`ifdef SNN_WEIGHT_LOADER_CHECKSUM_EN
            sum_q       <= '0;
            chk_phase_q <= 1'b0;
`endif
          end
        end
        ST_HI: begin
          // Strobe and address are launched together with the word itself.
          if (byte_xfer) begin
            we_q  <= 4'b0001 << layer_q;
            adr_q <= 32'(adr_cnt_q);
          end
        end
        ST_WR: begin
          if (!last_word) adr_cnt_q <= adr_cnt_q + CNT_W'(1);
`ifdef SNN_WEIGHT_LOADER_CHECKSUM_EN
          sum_q <= sum_q + 16'(word);
`endif
        end
        ST_NEXT: begin
          adr_cnt_q <= '0;
          layer_q   <= layer_q + 2'd1;
        end
`ifdef SNN_WEIGHT_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (byte_xfer && !chk_phase_q) begin
            chk_lo_q    <= i_byte_dat;
            chk_phase_q <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign o_byte_ready = ready_q;
  assign o_snn_adr    = adr_q;
  assign o_snn_we     = we_q;
  assign o_snn_dat    = word;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_snn_weight_loader.sv
// tb_snn_weight_loader: table-driven configuration checks plus hand-written
// sequences (byte order, stalled stream, start while busy, mid-load reset,
// checksum trailer). Writes are checked against a scoreboard queue.
module tb_snn_weight_loader;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n;
  logic        i_start;
  logic [6:0]  i_snn_input_channels, i_neuron_1, i_neuron_2, i_neuron_3, i_neuron_4;
  logic [2:0]  i_layers;
  logic [7:0]  i_byte_dat;
  logic        i_byte_valid;
  logic        o_byte_ready;
  logic [31:0] o_snn_adr;
  logic [3:0]  o_snn_we;
  logic [15:0] o_snn_dat;
  logic        o_busy, o_done, o_err;

  snn_weight_loader dut (
    .wb_clk               (wb_clk),
    .wb_rst_n             (wb_rst_n),
    .i_start              (i_start),
    .i_snn_input_channels (i_snn_input_channels),
    .i_neuron_1           (i_neuron_1),
    .i_neuron_2           (i_neuron_2),
    .i_neuron_3           (i_neuron_3),
    .i_neuron_4           (i_neuron_4),
    .i_layers             (i_layers),
    .i_byte_dat           (i_byte_dat),
    .i_byte_valid         (i_byte_valid),
    .o_byte_ready         (o_byte_ready),
    .o_snn_adr            (o_snn_adr),
    .o_snn_we             (o_snn_we),
    .o_snn_dat            (o_snn_dat),
    .o_busy               (o_busy),
    .o_done               (o_done),
    .o_err                (o_err)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct {
    logic [3:0]  we;
    logic [31:0] adr;
    logic [15:0] dat;
  } wr_t;

  typedef struct {
    int layers;
    int ch;
    int n1;
    int n2;
    int n3;
    int n4;
    bit exp_err;
  } cfg_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // Scoreboard: every strobe seen must match the oldest expected write.
  always @(negedge wb_clk) begin
    wr_t e;
    if (wb_rst_n === 1'b1 && o_snn_we !== 4'b0000) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: we=%b adr=%0d dat=0x%04h with no write expected",
                 o_snn_we, o_snn_adr, o_snn_dat);
      end else begin
        e = exp_q.pop_front();
        check("write_we", 32'(o_snn_we), 32'(e.we));
        check("write_adr", o_snn_adr, e.adr);
        check("write_dat", 32'(o_snn_dat), 32'(e.dat));
      end
    end
  end

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic apply_cfg(input cfg_t c);
    i_layers             = 3'(c.layers);
    i_snn_input_channels = 7'(c.ch);
    i_neuron_1           = 7'(c.n1);
    i_neuron_2           = 7'(c.n2);
    i_neuron_3           = 7'(c.n3);
    i_neuron_4           = 7'(c.n4);
  endtask

  task automatic start_cfg(input cfg_t c);
    apply_cfg(c);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Offer one byte and wait (bounded) for the handshake to complete.
  task automatic send_byte(input logic [7:0] b);
    i_byte_dat   = b;
    i_byte_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge wb_clk);
      if (o_byte_ready) begin
        @(posedge wb_clk);
        #1;
        i_byte_valid = 1'b0;
        return;
      end
    end
    i_byte_valid = 1'b0;
    checks++;
    errors++;
    $display("FAIL byte_handshake: ready never rose for byte 0x%02h (required within 50 cycles)", b);
  endtask

  task automatic send_word(input int layer, input int adr, input logic [15:0] w);
    wr_t e;
    e.we  = 4'(1 << layer);
    e.adr = 32'(adr);
    e.dat = w;
    exp_q.push_back(e);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
  endtask

  task automatic send_trailer(input logic [15:0] s);
`ifdef SNN_WEIGHT_LOADER_CHECKSUM_EN
    send_byte(s[7:0]);
    send_byte(s[15:8]);
`else
    if (s == 16'hFFFF) $display("note: trailer value unused in this build");
`endif
  endtask

  task automatic cfg_counts(input cfg_t c, output int cnt[4]);
    cnt[0] = c.ch * c.n1;
    cnt[1] = c.n1 * c.n2;
    cnt[2] = c.n2 * c.n3;
    cnt[3] = c.n3 * c.n4;
  endtask

  // Streams every word of every active layer, returning the running sum.
  task automatic stream_all(input cfg_t c, output logic [15:0] sum);
    int cnt[4];
    logic [15:0] w;
    cfg_counts(c, cnt);
    sum = 16'h0;
    for (int l = 0; l < c.layers; l++) begin
      for (int a = 0; a < cnt[l]; a++) begin
        w = 16'($urandom);
        sum = sum + w;
        send_word(l, a, w);
      end
    end
  endtask

  task automatic wait_status(input string name, input bit exp_done, input bit exp_err);
    for (int i = 0; i < 30; i++) begin
      if (o_done || o_err) break;
      tick();
    end
    check({name, "_done"}, 32'(o_done), 32'(exp_done));
    check({name, "_err"}, 32'(o_err), 32'(exp_err));
    check({name, "_busy"}, 32'(o_busy), 32'd0);
    check({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  cfg_t tbl[9];

  initial begin
    cfg_t        c;
    logic [15:0] sum;
    logic [15:0] w;
    logic [31:0] adr_hold;
    int          cnt[4];

    tbl[0] = '{2, 4, 3, 2, 1, 1, 1'b0};     // 12 + 6 words
    tbl[1] = '{0, 4, 3, 2, 1, 1, 1'b1};     // no layers
    tbl[2] = '{5, 4, 3, 2, 1, 1, 1'b1};     // too many layers
    tbl[3] = '{2, 4, 0, 2, 1, 1, 1'b1};     // n1 = 0
    tbl[4] = '{1, 127, 127, 1, 1, 1, 1'b1}; // 16129 words
    tbl[5] = '{1, 91, 91, 1, 1, 1, 1'b1};   // 8281 words, just past depth
    tbl[6] = '{1, 3, 5, 0, 0, 0, 1'b0};     // inactive zero counts ignored
    tbl[7] = '{4, 2, 3, 2, 2, 3, 1'b0};     // 6 + 6 + 4 + 6 words
    tbl[8] = '{3, 2, 2, 0, 1, 1, 1'b1};     // active layer 2 has zero words

    wb_rst_n = 1'b0;
    i_start = 1'b0;
    i_byte_valid = 1'b0;
    i_byte_dat = 8'h00;
    apply_cfg(tbl[0]);
    tick();
    tick();
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_done", 32'(o_done), 32'd0);
    check("reset_err", 32'(o_err), 32'd0);
    check("reset_ready", 32'(o_byte_ready), 32'd0);
    check("reset_we", 32'(o_snn_we), 32'd0);
    check("reset_adr", o_snn_adr, 32'd0);
    check("reset_dat", 32'(o_snn_dat), 32'd0);
    wb_rst_n = 1'b1;
    tick();

    // Configuration table: errors appear one cycle after start with no writes.
    for (int t = 0; t < 9; t++) begin
      $display("cfg %0d: layers=%0d ch=%0d n=%0d,%0d,%0d,%0d", t, tbl[t].layers, tbl[t].ch,
               tbl[t].n1, tbl[t].n2, tbl[t].n3, tbl[t].n4);
      start_cfg(tbl[t]);
      if (tbl[t].exp_err) begin
        check("cfg_err_after_start", 32'(o_err), 32'd1);
        check("cfg_err_busy", 32'(o_busy), 32'd0);
        check("cfg_err_ready", 32'(o_byte_ready), 32'd0);
        repeat (3) tick();
        check("cfg_err_held", 32'(o_err), 32'd1);
      end else begin
        check("cfg_busy_after_start", 32'(o_busy), 32'd1);
        check("cfg_ready_after_start", 32'(o_byte_ready), 32'd1);
        stream_all(tbl[t], sum);
        send_trailer(sum);
        wait_status("cfg_load", 1'b1, 1'b0);
      end
    end

    // Byte order and write timing on a single-word load.
    c = '{1, 1, 1, 0, 0, 0, 1'b0};
    start_cfg(c);
    begin
      wr_t e;
      e.we = 4'b0001; e.adr = 32'd0; e.dat = 16'h1234;
      exp_q.push_back(e);
    end
    send_byte(8'h34);
    check("order_no_we_after_lo", 32'(o_snn_we), 32'd0);
    send_byte(8'h12);
    check("order_we_cycle", 32'(o_snn_we), 32'h1);
    check("order_dat", 32'(o_snn_dat), 32'h1234);
    check("order_adr", o_snn_adr, 32'd0);
    tick();
    check("order_we_one_cycle", 32'(o_snn_we), 32'h0);
    check("order_dat_held", 32'(o_snn_dat), 32'h1234);
    send_trailer(16'h1234);
    wait_status("order", 1'b1, 1'b0);

    // Stalled stream mid-word, then a start pulse while busy.
    c = '{2, 2, 2, 2, 0, 0, 1'b0};
    cfg_counts(c, cnt);
    start_cfg(c);
    sum = 16'h0;
    for (int l = 0; l < 2; l++) begin
      for (int a = 0; a < cnt[l]; a++) begin
        w = 16'($urandom);
        sum = sum + w;
        if (l == 0 && a == 1) begin
          wr_t e;
          e.we = 4'b0001; e.adr = 32'd1; e.dat = w;
          exp_q.push_back(e);
          send_byte(w[7:0]);
          adr_hold = o_snn_adr;
          for (int s = 0; s < 10; s++) begin
            tick();
            if (o_snn_we != 4'b0000)
              check("stall_no_write", 32'(o_snn_we), 32'd0);
          end
          check("stall_adr_held", o_snn_adr, adr_hold);
          check("stall_ready", 32'(o_byte_ready), 32'd1);
          check("stall_busy", 32'(o_busy), 32'd1);
          send_byte(w[15:8]);
        end else begin
          send_word(l, a, w);
        end
        if (l == 1 && a == 0) begin
          i_layers = 3'd0;
          i_start = 1'b1;
          tick();
          i_start = 1'b0;
          check("busy_start_ignored", 32'(o_err), 32'd0);
        end
      end
    end
    send_trailer(sum);
    wait_status("stall", 1'b1, 1'b0);

    // Reset partway through layer 2, then a clean reload.
    c = tbl[0];
    start_cfg(c);
    for (int a = 0; a < 12; a++) send_word(0, a, 16'($urandom));
    send_word(1, 0, 16'hA5A5);
    send_word(1, 1, 16'h5A5A);
    send_byte(8'h77);
    #2;
    wb_rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_ready", 32'(o_byte_ready), 32'd0);
    check("midrst_we", 32'(o_snn_we), 32'd0);
    check("midrst_adr", o_snn_adr, 32'd0);
    check("midrst_dat", 32'(o_snn_dat), 32'd0);
    check("midrst_done_err", 32'({o_done, o_err}), 32'd0);
    exp_q.delete();
    tick();
    tick();
    wb_rst_n = 1'b1;
    tick();
    check("after_rst_idle", 32'({o_busy, o_done, o_err}), 32'd0);
    start_cfg(c);
    stream_all(c, sum);
    send_trailer(sum);
    wait_status("reload", 1'b1, 1'b0);

`ifdef SNN_WEIGHT_LOADER_CHECKSUM_EN
    // Trailer off by one must be flagged.
    c = '{1, 2, 3, 0, 0, 0, 1'b0};
    start_cfg(c);
    stream_all(c, sum);
    send_trailer(sum + 16'd1);
    wait_status("bad_checksum", 1'b0, 1'b1);
`endif

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
